// File: rtl/commit_trace_if.sv
// commit_trace_if: trace readout port of commit_trace_monitor.
//   master modport : monitor side; drives the head entry and trace_valid,
//                    and samples trace_ready.
//   slave modport  : consumer side; samples the head entry and drives
//                    trace_ready.
// Signals:
//   trace_valid        FIFO non-empty
//   trace_ready        consumer accepts the head entry
//   trace_pc           head entry pc
//   trace_instruction  head entry instruction word
//   trace_rd_index     head entry destination index (0 when no rf write)
//   trace_rd           head entry rd value (0 when trace_rd_index is 0)
//   trace_store        head entry mem_write_en
interface commit_trace_if #(
  parameter int XLEN = 32
);
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_instruction;
  logic [4:0]      trace_rd_index;
  logic [XLEN-1:0] trace_rd;
  logic            trace_store;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_instruction,
    output trace_rd_index,
    output trace_rd,
    output trace_store,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_instruction,
    input  trace_rd_index,
    input  trace_rd,
    input  trace_store,
    output trace_ready
  );
endinterface

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: run monitor beside a single-cycle RV32I core.
// Counts running cycles and retired instructions, detects halt (pc self-loop
// held for HALT_COUNT running cycles) and cycle-budget timeout, and buffers
// one trace entry per retired instruction in a DEPTH-entry FIFO.
// Ports:
//   clk, reset (async, active-low)
//   enable                     run qualifier (IDLE -> RUN, pause in RUN)
//   pc, pc_next, instruction   core fetch/next-pc observation
//   rd_index, rd, rf_write_en  register-file write observation
//   mem_write_en               data store observation
//   trace                      FIFO head / valid-ready readout (master)
//   state, halted, timeout     run state (0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT)
//   cycle_count, retired_count saturating counters
//   trace_count, overflow      FIFO occupancy and sticky drop flag
module commit_trace_monitor #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 1024,
  parameter int HALT_COUNT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        pc_next,
  input  logic [31:0]            instruction,
  input  logic [4:0]             rd_index,
  input  logic [XLEN-1:0]        rd,
  input  logic                   rf_write_en,
  input  logic                   mem_write_en,
  commit_trace_if.master         trace,
  output logic [1:0]             state,
  output logic                   halted,
  output logic                   timeout,
  output logic [31:0]            cycle_count,
  output logic [31:0]            retired_count,
  output logic [$clog2(DEPTH):0] trace_count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (HALT_COUNT < 1) ? 1 : $clog2(HALT_COUNT + 1);
  localparam logic [SW-1:0] HALT_LIM = SW'(HALT_COUNT);
  localparam logic [31:0]   MAX_LIM  = 32'(MAX_CYCLES);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd_index;
    logic [XLEN-1:0] rd;
    logic            store;
  } entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [31:0]     cycle_q, cycle_d;
  logic [31:0]     retired_q, retired_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            overflow_q;
  entry_t          head_q, head_d;
  entry_t          mem [DEPTH];
  entry_t          new_entry;
  logic [4:0]      masked_index;
  logic            running, retire, pop, push_ok, drop;

  // Run control: a retirement is a running cycle that does not continue an
  // existing self-loop streak, so a halting loop is recorded exactly once.
  always_comb begin
    running   = (state_q == S_RUN) && enable;
    retire    = running && (streak_q == '0);
    streak_d  = streak_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    state_d   = state_q;
    if (running) begin
      cycle_d = sat_inc32(cycle_q);
      if (pc_next == pc) begin
        streak_d = (streak_q == '1) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
    if (retire) begin
      retired_d = sat_inc32(retired_q);
    end
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        // Halt is checked first so a same-cycle halt and timeout reports halt.
        if (running) begin
          if (streak_d >= HALT_LIM)    state_d = S_HALTED;
          else if (cycle_d >= MAX_LIM) state_d = S_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign masked_index       = rf_write_en ? rd_index : 5'd0;
  assign new_entry.pc       = pc;
  assign new_entry.instr    = instruction;
  assign new_entry.rd_index = masked_index;
  assign new_entry.rd       = (masked_index == 5'd0) ? '0 : rd;
  assign new_entry.store    = mem_write_en;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = (count_q != '0) && trace.trace_ready;
  assign push_ok = retire && ((count_q != FULL_LVL) || pop);
  assign drop    = retire && (count_q == FULL_LVL) && !pop;

  // The head register holds the entry that will sit at rd_ptr after this
  // edge, so trace_* come straight from flops with no read latency. The new
  // entry bypasses the array when it becomes the head immediately.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    if (count_d == '0) begin
      head_d = '0;
    end else if (push_ok && (count_q == (pop ? CW'(1) : CW'(0)))) begin
      head_d = new_entry;
    end else begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      streak_q   <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_q | drop;
      head_q     <= head_d;
    end
  end

  // Entry storage: contents are only observed through head_q, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= new_entry;
  end

  assign state                   = state_q;
  assign halted                  = (state_q == S_HALTED);
  assign timeout                 = (state_q == S_TIMEOUT);
  assign cycle_count             = cycle_q;
  assign retired_count           = retired_q;
  assign trace_count             = count_q;
  assign overflow                = overflow_q;
  assign trace.trace_valid       = (count_q != '0);
  assign trace.trace_pc          = head_q.pc;
  assign trace.trace_instruction = head_q.instr;
  assign trace.trace_rd_index    = head_q.rd_index;
  assign trace.trace_rd          = head_q.rd;
  assign trace.trace_store       = head_q.store;
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: two monitor instances on one shared core stream.
//   dut_a: DEPTH 16, MAX_CYCLES 1024, HALT_COUNT 2 (straight-line, halt)
//   dut_b: DEPTH 4,  MAX_CYCLES 8,    HALT_COUNT 2 (overflow, full, timeout)
// Expected trace entries are queued when a retiring cycle is driven and
// popped/compared when the bench accepts the head entry.
module tb_commit_trace_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] pc, pc_next, instruction, rd;
  logic [4:0]  rd_index;
  logic        rf_write_en, mem_write_en;

  logic [1:0]  state_a, state_b;
  logic        halted_a, halted_b, timeout_a, timeout_b;
  logic [31:0] cycle_a, cycle_b, retired_a, retired_b;
  logic [4:0]  count_a;
  logic [2:0]  count_b;
  logic        overflow_a, overflow_b;

  commit_trace_if #(.XLEN(32)) ifa ();
  commit_trace_if #(.XLEN(32)) ifb ();

  always #5 clk = ~clk;

  commit_trace_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(1024), .HALT_COUNT(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .pc_next(pc_next),
    .instruction(instruction), .rd_index(rd_index), .rd(rd),
    .rf_write_en(rf_write_en), .mem_write_en(mem_write_en), .trace(ifa),
    .state(state_a), .halted(halted_a), .timeout(timeout_a),
    .cycle_count(cycle_a), .retired_count(retired_a),
    .trace_count(count_a), .overflow(overflow_a)
  );

  commit_trace_monitor #(.XLEN(32), .DEPTH(4), .MAX_CYCLES(8), .HALT_COUNT(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .pc_next(pc_next),
    .instruction(instruction), .rd_index(rd_index), .rd(rd),
    .rf_write_en(rf_write_en), .mem_write_en(mem_write_en), .trace(ifb),
    .state(state_b), .halted(halted_b), .timeout(timeout_b),
    .cycle_count(cycle_b), .retired_count(retired_b),
    .trace_count(count_b), .overflow(overflow_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  idx;
    logic [31:0] rd;
    logic        st;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  idx;
    logic [31:0] rdv;
    logic        rfwe;
    logic        mwe;
    int          exp_ret;
    int          exp_cnt_b;
    logic        exp_ovf_b;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  ent_t qa[$];
  ent_t qb[$];
  ent_t dummy;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] idx,
                              input logic [31:0] v, input logic we, input logic mw);
    ent_t e;
    e.pc    = p;
    e.instr = ins;
    e.idx   = we ? idx : 5'd0;
    e.rd    = (e.idx == 5'd0) ? 32'h0 : v;
    e.st    = mw;
    return e;
  endfunction

  task automatic cmp_head(input string t, input logic v, input logic [31:0] p, input logic [31:0] ins,
                          input logic [4:0] idx, input logic [31:0] r, input logic st, input ent_t m);
    chk({t, "_valid"}, 64'(v), 64'(1'b1));
    chk({t, "_pc"}, 64'(p), 64'(m.pc));
    chk({t, "_instr"}, 64'(ins), 64'(m.instr));
    chk({t, "_rd_index"}, 64'(idx), 64'(m.idx));
    chk({t, "_rd"}, 64'(r), 64'(m.rd));
    chk({t, "_store"}, 64'(st), 64'(m.st));
  endtask

  // One clock: compare heads being accepted, then update the scoreboards
  // (pop before push, so a full FIFO with pop accepts the push).
  task automatic tick(input bit push, input ent_t e);
    bit pa, pb;
    pa = ifa.trace_ready && (qa.size() > 0);
    pb = ifb.trace_ready && (qb.size() > 0);
    if (pa) cmp_head("head_a", ifa.trace_valid, ifa.trace_pc, ifa.trace_instruction,
                     ifa.trace_rd_index, ifa.trace_rd, ifa.trace_store, qa[0]);
    if (pb) cmp_head("head_b", ifb.trace_valid, ifb.trace_pc, ifb.trace_instruction,
                     ifb.trace_rd_index, ifb.trace_rd, ifb.trace_store, qb[0]);
    @(posedge clk);
    if (pa) dummy = qa.pop_front();
    if (pb) dummy = qb.pop_front();
    if (push) begin
      if (qa.size() < 16) qa.push_back(e);
      if (qb.size() < 4)  qb.push_back(e);
    end
    #1;
  endtask

  task automatic step(input logic [31:0] p, input logic [31:0] pn, input logic [31:0] ins,
                      input logic [4:0] idx, input logic [31:0] v, input logic we,
                      input logic mw, input bit push);
    pc = p; pc_next = pn; instruction = ins; rd_index = idx; rd = v;
    rf_write_en = we; mem_write_en = mw;
    tick(push, mk(p, ins, idx, v, we, mw));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b1;
    ifa.trace_ready = 1'b0;
    ifb.trace_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{32'h00, 32'h00100093, 5'd1, 32'h0000_0011, 1'b1, 1'b0, 1, 1, 1'b0};
    vt[1] = '{32'h04, 32'h00200113, 5'd2, 32'h0000_0022, 1'b1, 1'b0, 2, 2, 1'b0};
    vt[2] = '{32'h08, 32'h00300193, 5'd3, 32'h0000_0033, 1'b1, 1'b0, 3, 3, 1'b0};
    vt[3] = '{32'h0C, 32'h00400213, 5'd4, 32'h0000_0044, 1'b1, 1'b0, 4, 4, 1'b0};
    vt[4] = '{32'h10, 32'h00500293, 5'd5, 32'h0000_0055, 1'b1, 1'b0, 5, 4, 1'b1};
    vt[5] = '{32'h14, 32'h00502023, 5'd7, 32'h0000_DEAD, 1'b0, 1'b1, 6, 4, 1'b1};
    vt[6] = '{32'h18, 32'h00000013, 5'd0, 32'h0000_BEEF, 1'b1, 1'b0, 7, 4, 1'b1};

    // Reset held for two edges with enable high
    reset = 1'b0; enable = 1'b1;
    pc = 32'h0; pc_next = 32'h4; instruction = 32'h0; rd_index = 5'd0; rd = 32'h0;
    rf_write_en = 1'b0; mem_write_en = 1'b0;
    ifa.trace_ready = 1'b0; ifb.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state_a), 64'(2'd0));
    chk("rst_cycle", 64'(cycle_a), 64'(0));
    chk("rst_retired", 64'(retired_a), 64'(0));
    chk("rst_count", 64'(count_a), 64'(0));
    chk("rst_valid", 64'(ifa.trace_valid), 64'(0));
    chk("rst_pc", 64'(ifa.trace_pc), 64'(0));
    chk("rst_flags", 64'({halted_a, timeout_a, overflow_a}), 64'(0));
    reset = 1'b1;
    tick(1'b0, '0);
    chk("release_state", 64'(state_a), 64'(2'd1));
    chk("release_cycle", 64'(cycle_a), 64'(0));

    // Straight-line code, no readout; dut_b overflows past four entries
    for (int i = 0; i < 7; i++) begin
      step(vt[i].pc, vt[i].pc + 32'd4, vt[i].instr, vt[i].idx, vt[i].rdv, vt[i].rfwe, vt[i].mwe, 1'b1);
      chk($sformatf("sl%0d_retired_a", i), 64'(retired_a), 64'(vt[i].exp_ret));
      chk($sformatf("sl%0d_count_a", i), 64'(count_a), 64'(vt[i].exp_ret));
      chk($sformatf("sl%0d_retired_b", i), 64'(retired_b), 64'(vt[i].exp_ret));
      chk($sformatf("sl%0d_count_b", i), 64'(count_b), 64'(vt[i].exp_cnt_b));
      chk($sformatf("sl%0d_ovf_b", i), 64'(overflow_b), 64'(vt[i].exp_ovf_b));
    end
    chk("sl_valid_a", 64'(ifa.trace_valid), 64'(1));

    // Paused readout of both FIFOs, then pops past empty
    enable = 1'b0;
    ifa.trace_ready = 1'b1; ifb.trace_ready = 1'b1;
    repeat (8) tick(1'b0, '0);
    chk("drain_valid_a", 64'(ifa.trace_valid), 64'(0));
    chk("drain_count_a", 64'(count_a), 64'(0));
    chk("drain_count_b", 64'(count_b), 64'(0));
    chk("drain_ovf_b", 64'(overflow_b), 64'(1));
    chk("pause_cycle_a", 64'(cycle_a), 64'(7));
    chk("pause_state_a", 64'(state_a), 64'(2'd1));

    // Full FIFO with simultaneous push and pop, then async reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++)
      step(32'h40 + 32'(4 * i), 32'h44 + 32'(4 * i), 32'h00000013 + 32'(i), 5'(i + 1),
           32'h100 + 32'(i), 1'b1, 1'b0, 1'b1);
    chk("full_count_b", 64'(count_b), 64'(4));
    chk("full_ovf_b", 64'(overflow_b), 64'(0));
    ifb.trace_ready = 1'b1;
    step(32'h50, 32'h54, 32'h00a00513, 5'd10, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("pushpop_count_b", 64'(count_b), 64'(4));
    chk("pushpop_ovf_b", 64'(overflow_b), 64'(0));
    chk("pushpop_retired_b", 64'(retired_b), 64'(5));
    enable = 1'b0;
    tick(1'b0, '0);
    ifb.trace_ready = 1'b0;
    chk("pre_rst_count_b", 64'(count_b), 64'(3));
    #3 reset = 1'b0;
    #1;
    chk("arst_state_b", 64'(state_b), 64'(0));
    chk("arst_count_b", 64'(count_b), 64'(0));
    chk("arst_valid_b", 64'(ifb.trace_valid), 64'(0));
    chk("arst_counters_b", 64'({cycle_b, retired_b}), 64'(0));
    chk("arst_state_a", 64'(state_a), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    qa.delete(); qb.delete();
    enable = 1'b1;
    tick(1'b0, '0);

    // Halt: jump into a self-loop held four cycles
    step(32'h1C, 32'h20, 32'h0040006f, 5'd1, 32'h20, 1'b1, 1'b0, 1'b1);
    step(32'h20, 32'h20, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("halt1_halted_a", 64'(halted_a), 64'(0));
    chk("halt1_retired_a", 64'(retired_a), 64'(2));
    step(32'h20, 32'h20, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("halt2_halted_a", 64'(halted_a), 64'(1));
    chk("halt2_state_a", 64'(state_a), 64'(2'd2));
    chk("halt2_halted_b", 64'(halted_b), 64'(1));
    repeat (2) step(32'h20, 32'h20, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("halt_retired_a", 64'(retired_a), 64'(2));
    chk("halt_cycle_a", 64'(cycle_a), 64'(3));
    chk("halt_count_a", 64'(count_a), 64'(2));
    ifa.trace_ready = 1'b1;
    repeat (2) tick(1'b0, '0);
    ifa.trace_ready = 1'b0;
    chk("halt_drain_valid_a", 64'(ifa.trace_valid), 64'(0));

    // Timeout on dut_b, delayed by a three-cycle pause
    do_reset();
    for (int i = 0; i < 4; i++)
      step(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    repeat (3) tick(1'b0, '0);
    chk("to_pause_cycle_b", 64'(cycle_b), 64'(4));
    enable = 1'b1;
    for (int i = 4; i < 7; i++)
      step(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("to7_timeout_b", 64'(timeout_b), 64'(0));
    chk("to7_cycle_b", 64'(cycle_b), 64'(7));
    step(32'h11C, 32'h120, 32'h00000013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("to8_timeout_b", 64'(timeout_b), 64'(1));
    chk("to8_state_b", 64'(state_b), 64'(2'd3));
    chk("to8_cycle_b", 64'(cycle_b), 64'(8));
    chk("to8_timeout_a", 64'(timeout_a), 64'(0));
    chk("to8_ovf_b", 64'(overflow_b), 64'(1));
    step(32'h120, 32'h124, 32'h00000013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("to_frozen_cycle_b", 64'(cycle_b), 64'(8));
    chk("to_frozen_retired_b", 64'(retired_b), 64'(8));

    // Halt and timeout on the same edge: halt takes priority
    do_reset();
    for (int i = 0; i < 6; i++)
      step(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h300, 32'h300, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("prio7_state_b", 64'(state_b), 64'(2'd1));
    step(32'h300, 32'h300, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prio_state_b", 64'(state_b), 64'(2'd2));
    chk("prio_flags_b", 64'({halted_b, timeout_b}), 64'(2'b10));
    chk("prio_cycle_b", 64'(cycle_b), 64'(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Synthesizable, parametrised run monitor that sits beside the single-cycle RV32I core and observes its per-cycle architectural signals. It counts retired instructions and running cycles, detects program halt (self-loop) and cycle-budget timeout, and buffers a per-instruction commit trace in a FIFO drained through a valid/ready port. It replaces per-cycle console dumps with a checkable, bounded record that a bench or a debug host can read out.

## Interface

Parameters:
- XLEN, 32, datapath width of pc, rd, store address and store data.
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- MAX_CYCLES, 1024, running-cycle budget before timeout; at least 1.
- HALT_COUNT, 2, consecutive running cycles with pc_next == pc that declare halt; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start/run qualifier; a cycle is "running" when state is RUN and enable is 1.
- pc  in  XLEN  address of the instruction executing this cycle.
- pc_next  in  XLEN  address the core loads at the next edge.
- instruction  in  32  instruction word at pc.
- rd_index  in  5  destination register index.
- rd  in  XLEN  value written to rd.
- rf_write_en  in  1  register-file write this cycle.
- mem_write_en  in  1  data-memory store this cycle.
- trace_ready  in  1  consumer accepts the head entry.
- state  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT.
- halted  out  1  state == HALTED.
- timeout  out  1  state == TIMEOUT.
- cycle_count  out  32  running cycles seen.
- retired_count  out  32  instructions captured as retired.
- trace_valid  out  1  FIFO non-empty.
- trace_pc  out  XLEN  head entry pc.
- trace_instruction  out  32  head entry instruction.
- trace_rd_index  out  5  head entry rd_index; 0 when rf_write_en was 0.
- trace_rd  out  XLEN  head entry rd value; 0 when trace_rd_index is 0.
- trace_store  out  1  head entry mem_write_en.
- trace_count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky; an entry was dropped.

## Operation

- State machine: IDLE -> RUN when enable is 1; RUN holds with enable 0 (paused: no counting, no capture); RUN -> HALTED when halt streak reaches HALT_COUNT; RUN -> TIMEOUT when cycle_count reaches MAX_CYCLES. Same-cycle halt and timeout: HALTED wins. HALTED and TIMEOUT are terminal until reset.
- Each running cycle: cycle_count +1. Halt streak +1 if pc_next == pc, otherwise cleared. A paused cycle leaves the streak unchanged.
- Retire/push: a running cycle with streak 0 before the update is a retirement. retired_count +1; the entry {pc, instruction, rf_write_en ? rd_index : 0, masked rd, mem_write_en} is pushed. A self-loop instruction is therefore recorded once.
- Pop: trace_valid && trace_ready removes the head.
- Full, push without pop: entry dropped, overflow set, retired_count still increments. Full with push and pop together: both occur, trace_count unchanged. Pop when empty: ignored.
- Readout is allowed in every state, including after halt or timeout.
- Counters saturate at all-ones.

## Timing

- Reset (asynchronous, any time including mid-run or mid-readout): state IDLE, all counters 0, FIFO empty, overflow 0, every output 0.
- All outputs are registered. trace_* present the head entry directly, with no extra read latency.
- A push at edge N is visible on the outputs after edge N (trace_valid 1 in cycle N+1) if the FIFO was empty.
- Pop at edge N: the next entry appears, or trace_valid drops, after edge N.
- Halt: the HALT_COUNT-th consecutive self-loop cycle sets halted after that edge.
- Timeout: the MAX_CYCLES-th running cycle sets timeout after that edge.
- Pointers wrap modulo DEPTH. trace_count is exact at every edge.

## Test plan

- Reset: hold reset low for 2 cycles with enable 1 -> state 0, all counters, flags and trace outputs 0. Release reset -> state 1 one edge later.
- Straight-line code: feed pc 0,4,8,0xC,0x10, all with rf_write_en 1, rd_index 1..5, trace_ready 0 -> retired_count 5, trace_count 5. Then pop with trace_ready 1 -> entries arrive in order with the matching pc and rd values.
- Halt with HALT_COUNT=2: feed pc=pc_next=0x20 for 4 cycles -> halted after the 2nd such edge, one entry for 0x20, retired_count frozen.
- Overflow with DEPTH=4: push 6 entries, trace_ready 0 -> trace_count 4, overflow 1, retired_count 6. Entries read out are the first four pushed.
- Timeout with MAX_CYCLES=8: advancing pc, no self-loop -> timeout 1 after the 8th running cycle, cycle_count 8. Pausing enable for 3 cycles mid-run delays the timeout by 3 cycles.
- Full FIFO: push and pop in the same cycle -> trace_count stays 4, no overflow. Asserting reset mid-run with 3 entries buffered -> FIFO empty and state 0 immediately, without waiting for a clock edge.
